// File: rtl/ibex_pkg.sv
// Shared constants for the HPM control block: CSR addresses and an indexed-address helper.
package ibex_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
    localparam logic [11:0] CSR_MHPMOVF       = 12'h7C0;

    function automatic logic [11:0] csr_idx_addr(input logic [11:0] base, input int unsigned idx);
        return base + 12'(idx);
    endfunction

endpackage

// File: rtl/ibex_hpm_ctrl_if.sv
// CSR access bus between the CSR file (master) and the HPM control block (slave).
interface ibex_hpm_ctrl_if;

    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;

    modport master (output csr_we_i, csr_addr_i, csr_wdata_i, input csr_rdata_o);
    modport slave  (input csr_we_i, csr_addr_i, csr_wdata_i, output csr_rdata_o);

endinterface

// File: rtl/ibex_hpm_event_sel.sv
// Per-counter increment qualifier: event mask, inhibit, and suppression while software loads the counter.
module ibex_hpm_event_sel #(
    parameter int unsigned NumEvents = 8
) (
    input  logic [NumEvents-1:0] events_q_i,
    input  logic [NumEvents-1:0] event_sel_i,
    input  logic                 inhibit_i,
    input  logic                 counter_we_i,
    input  logic                 counterh_we_i,
    output logic                 counter_inc_o
);

    // A software load on either half wins over a coincident event; that event is dropped.
    assign counter_inc_o = (|(events_q_i & event_sel_i)) & ~inhibit_i
                           & ~(counter_we_i | counterh_we_i);

endmodule

// File: rtl/ibex_hpm_ctrl.sv
// HPM control: event selection, inhibit and load strobes for mhpmcounter3..; overflow
// flags and interrupt exist only when IBEX_HPM_OVF_IRQ_EN is defined.
module ibex_hpm_ctrl
    import ibex_pkg::*;
#(
    parameter int unsigned NumCounters = 4,
    parameter int unsigned NumEvents   = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    ibex_hpm_ctrl_if.slave              csr_bus,
    input  logic [NumEvents-1:0]        events_i,
    input  logic [NumCounters*64-1:0]   counter_val_i,
    output logic [NumCounters-1:0]      counter_inc_o,
    output logic [NumCounters-1:0]      counter_we_o,
    output logic [NumCounters-1:0]      counterh_we_o,
    output logic [31:0]                 counter_wdata_o,
    output logic                        ovf_irq_o
);

    logic [NumEvents-1:0]   events_q;
    logic [NumCounters-1:0] mcountinhibit_q, mcountinhibit_d;
    logic [NumEvents-1:0]   mhpmevent_q [NumCounters];
    logic [NumEvents-1:0]   mhpmevent_d [NumCounters];

    assign counter_wdata_o = csr_bus.csr_wdata_i;

    always_comb begin
        mcountinhibit_d = mcountinhibit_q;
        mhpmevent_d     = mhpmevent_q;
        counter_we_o    = '0;
        counterh_we_o   = '0;
        if (csr_bus.csr_we_i) begin
            if (csr_bus.csr_addr_i == CSR_MCOUNTINHIBIT) begin
                mcountinhibit_d = csr_bus.csr_wdata_i[3 +: NumCounters];
            end
            for (int unsigned i = 0; i < NumCounters; i++) begin
                if (csr_bus.csr_addr_i == csr_idx_addr(CSR_MHPMEVENT3, i)) begin
                    mhpmevent_d[i] = csr_bus.csr_wdata_i[NumEvents-1:0];
                end
                counter_we_o[i]  = (csr_bus.csr_addr_i == csr_idx_addr(CSR_MHPMCOUNTER3, i));
                counterh_we_o[i] = (csr_bus.csr_addr_i == csr_idx_addr(CSR_MHPMCOUNTER3H, i));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            events_q        <= '0;
            mcountinhibit_q <= '0;
            for (int unsigned i = 0; i < NumCounters; i++) begin
                mhpmevent_q[i] <= '0;
            end
        end else begin
            events_q        <= events_i;
            mcountinhibit_q <= mcountinhibit_d;
            mhpmevent_q     <= mhpmevent_d;
        end
    end

    for (genvar g = 0; g < NumCounters; g++) begin : g_event_sel
        ibex_hpm_event_sel #(
            .NumEvents (NumEvents)
        ) u_event_sel (
            .events_q_i    (events_q),
            .event_sel_i   (mhpmevent_q[g]),
            .inhibit_i     (mcountinhibit_q[g]),
            .counter_we_i  (counter_we_o[g]),
            .counterh_we_i (counterh_we_o[g]),
            .counter_inc_o (counter_inc_o[g])
        );
    end

`ifdef IBEX_HPM_OVF_IRQ_EN
    logic [NumCounters-1:0] ovf_q, ovf_d, ovf_set, ovf_clr;

    always_comb begin
        ovf_set = '0;
        for (int unsigned i = 0; i < NumCounters; i++) begin
            ovf_set[i] = counter_inc_o[i] & (counter_val_i[64*i +: 64] == {64{1'b1}});
        end
        ovf_clr = (csr_bus.csr_we_i && csr_bus.csr_addr_i == CSR_MHPMOVF) ?
                  csr_bus.csr_wdata_i[NumCounters-1:0] : '0;
        // Set is applied after clear so a simultaneous wrap is never lost.
        ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_irq_o = |ovf_q;
`else
    logic unused_counter_val;
    assign unused_counter_val = ^counter_val_i;
    assign ovf_irq_o = 1'b0;
`endif

    always_comb begin
        csr_bus.csr_rdata_o = '0;
        if (csr_bus.csr_addr_i == CSR_MCOUNTINHIBIT) begin
            csr_bus.csr_rdata_o[3 +: NumCounters] = mcountinhibit_q;
        end
        for (int unsigned i = 0; i < NumCounters; i++) begin
            if (csr_bus.csr_addr_i == csr_idx_addr(CSR_MHPMEVENT3, i)) begin
                csr_bus.csr_rdata_o[NumEvents-1:0] = mhpmevent_q[i];
            end
        end
`ifdef IBEX_HPM_OVF_IRQ_EN
        if (csr_bus.csr_addr_i == CSR_MHPMOVF) begin
            csr_bus.csr_rdata_o[NumCounters-1:0] = ovf_q;
        end
`endif
    end

endmodule

// File: tb/tb_ibex_hpm_ctrl.sv
// Randomized bench for ibex_hpm_ctrl against a cycle-level model of the CSR/event rules,
// plus directed scenarios with literal expectations.
module tb_ibex_hpm_ctrl;

    localparam int NC = 4;
    localparam int NE = 8;
    localparam logic [11:0] A_INH  = 12'h320;
    localparam logic [11:0] A_EVT  = 12'h323;
    localparam logic [11:0] A_CNT  = 12'hB03;
    localparam logic [11:0] A_CNTH = 12'hB83;
    localparam logic [11:0] A_OVF  = 12'h7C0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ibex_hpm_ctrl_if bus ();
    logic [NE-1:0]    events;
    logic [NC*64-1:0] cval;
    logic [NC-1:0]    inc, we, weh;
    logic [31:0]      wdo;
    logic             irq;

    ibex_hpm_ctrl #(.NumCounters(NC), .NumEvents(NE)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .csr_bus         (bus),
        .events_i        (events),
        .counter_val_i   (cval),
        .counter_inc_o   (inc),
        .counter_we_o    (we),
        .counterh_we_o   (weh),
        .counter_wdata_o (wdo),
        .ovf_irq_o       (irq)
    );

    int checks = 0;
    int errors = 0;

    logic [NC-1:0] m_inh;
    logic [NE-1:0] m_sel [NC];
    logic [NE-1:0] m_evq;
    logic [NC-1:0] m_ovf;
    logic [NC-1:0] m_inc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_inh = '0;
        m_evq = '0;
        m_ovf = '0;
        m_inc = '0;
        for (int i = 0; i < NC; i++) m_sel[i] = '0;
    endtask

    function automatic int evt_index(input logic [11:0] a);
        int k;
        k = int'(a) - int'(A_EVT);
        return (k >= 0 && k < NC) ? k : -1;
    endfunction

    task automatic compare();
        logic [NC-1:0] ew, ewh, ei;
        logic [31:0]   er;
        int            k;
        for (int i = 0; i < NC; i++) begin
            ew[i]  = bus.csr_we_i && (bus.csr_addr_i == A_CNT + 12'(i));
            ewh[i] = bus.csr_we_i && (bus.csr_addr_i == A_CNTH + 12'(i));
            ei[i]  = (|(m_evq & m_sel[i])) && !m_inh[i] && !ew[i] && !ewh[i];
        end
        er = '0;
        k  = evt_index(bus.csr_addr_i);
        if (bus.csr_addr_i == A_INH) er = 32'(m_inh) << 3;
        else if (k >= 0) er = 32'(m_sel[k]);
`ifdef IBEX_HPM_OVF_IRQ_EN
        else if (bus.csr_addr_i == A_OVF) er = 32'(m_ovf);
`endif
        m_inc = ei;
        chk("counter_inc", 64'(inc), 64'(ei));
        chk("counter_we", 64'(we), 64'(ew));
        chk("counterh_we", 64'(weh), 64'(ewh));
        chk("counter_wdata", 64'(wdo), 64'(bus.csr_wdata_i));
        chk("csr_rdata", 64'(bus.csr_rdata_o), 64'(er));
        chk("ovf_irq", 64'(irq), 64'(|m_ovf));
    endtask

    task automatic advance();
        int k;
`ifdef IBEX_HPM_OVF_IRQ_EN
        logic [NC-1:0] set, clr;
        for (int i = 0; i < NC; i++) set[i] = m_inc[i] && (cval[64*i +: 64] == {64{1'b1}});
        clr = (bus.csr_we_i && bus.csr_addr_i == A_OVF) ? bus.csr_wdata_i[NC-1:0] : '0;
        m_ovf = (m_ovf & ~clr) | set;
`endif
        if (bus.csr_we_i) begin
            if (bus.csr_addr_i == A_INH) m_inh = bus.csr_wdata_i[3 +: NC];
            k = evt_index(bus.csr_addr_i);
            if (k >= 0) m_sel[k] = bus.csr_wdata_i[NE-1:0];
        end
        m_evq = events;
    endtask

    task automatic cyc(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [NE-1:0] e, input logic [NC*64-1:0] cv);
        @(negedge clk);
        bus.csr_we_i    = w;
        bus.csr_addr_i  = a;
        bus.csr_wdata_i = d;
        events          = e;
        cval            = cv;
        #1;
        compare();
        advance();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_inc"}, 64'(inc), 64'd0);
        chk({tag, "_we"}, 64'({we, weh}), 64'd0);
        chk({tag, "_wdata"}, 64'(wdo), 64'd0);
        chk({tag, "_rdata"}, 64'(bus.csr_rdata_o), 64'd0);
        chk({tag, "_irq"}, 64'(irq), 64'd0);
    endtask

    task automatic do_reset(input logic [NC*64-1:0] cv);
        @(negedge clk);
        bus.csr_we_i    = 1'b0;
        bus.csr_addr_i  = A_EVT;
        bus.csr_wdata_i = '0;
        events          = '0;
        cval            = cv;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("reset");
        compare();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [NC*64-1:0] rand_cval();
        logic [NC*64-1:0] v;
        for (int i = 0; i < NC; i++) begin
            if ($urandom_range(0, 3) == 0) v[64*i +: 64] = {64{1'b1}};
            else v[64*i +: 64] = {$urandom, $urandom};
        end
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC*64-1:0] cv0;
        logic [11:0]      a;
        logic             w;
        cv0 = '0;
        bus.csr_we_i    = 1'b0;
        bus.csr_addr_i  = A_EVT;
        bus.csr_wdata_i = '0;
        events          = '0;
        cval            = '0;
        model_reset();
        #2;
        check_all_zero("init");
        @(negedge clk);
        rst_n = 1'b1;

        // Event 0 selected for counter 0: pulse at t increments at t+1 only.
        cyc(1, A_EVT, 32'h1, 8'h00, cv0);
        cyc(0, 12'h0, 32'h0, 8'h01, cv0);
        cyc(0, 12'h0, 32'h0, 8'h00, cv0);
        chk("evt_pulse_t1", 64'(inc[0]), 64'd1);
        cyc(0, 12'h0, 32'h0, 8'h00, cv0);
        chk("evt_pulse_t2", 64'(inc[0]), 64'd0);

        // Inhibit holds counter 0; clearing it resumes from the following cycle.
        cyc(1, A_INH, 32'h8, 8'h00, cv0);
        cyc(0, A_INH, 32'h0, 8'h01, cv0);
        chk("inh_readback", 64'(bus.csr_rdata_o), 64'h8);
        cyc(0, 12'h0, 32'h0, 8'h01, cv0);
        chk("inh_hold_a", 64'(inc[0]), 64'd0);
        cyc(1, A_INH, 32'h0, 8'h01, cv0);
        chk("inh_old_setting", 64'(inc[0]), 64'd0);
        cyc(0, 12'h0, 32'h0, 8'h00, cv0);
        chk("inh_resume", 64'(inc[0]), 64'd1);

        // Counter load collides with a qualifying event: load wins.
        cyc(0, 12'h0, 32'h0, 8'h01, cv0);
        cyc(1, A_CNT, 32'h1234, 8'h00, cv0);
        chk("load_we", 64'(we[0]), 64'd1);
        chk("load_inc", 64'(inc[0]), 64'd0);
        chk("load_wdata", 64'(wdo), 64'h1234);

        // Event select width truncation.
        cyc(1, A_EVT, 32'hFFFF_FFFF, 8'h00, cv0);
        cyc(0, A_EVT, 32'h0, 8'h00, cv0);
        chk("evt_readback", 64'(bus.csr_rdata_o), 64'hFF);

`ifdef IBEX_HPM_OVF_IRQ_EN
        cv0[63:0] = {64{1'b1}};
        cyc(0, 12'h0, 32'h0, 8'h01, cv0);
        cyc(0, 12'h0, 32'h0, 8'h00, cv0);
        chk("ovf_inc", 64'(inc[0]), 64'd1);
        chk("ovf_irq_before", 64'(irq), 64'd0);
        cyc(0, A_OVF, 32'h0, 8'h00, cv0);
        chk("ovf_irq_set", 64'(irq), 64'd1);
        chk("ovf_readback", 64'(bus.csr_rdata_o), 64'h1);
        cyc(1, A_OVF, 32'h1, 8'h00, cv0);
        cyc(0, 12'h0, 32'h0, 8'h00, cv0);
        chk("ovf_irq_clr", 64'(irq), 64'd0);
        cv0 = '0;
`else
        cyc(0, A_OVF, 32'h0, 8'h00, cv0);
        chk("ovf_absent_rdata", 64'(bus.csr_rdata_o), 64'd0);
        chk("ovf_absent_irq", 64'(irq), 64'd0);
`endif

        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                cyc(1, A_EVT, 32'hFF, 8'hFF, rand_cval());
                do_reset(rand_cval());
            end
            case ($urandom_range(0, 5))
                0: a = A_INH;
                1: a = A_EVT + 12'($urandom_range(0, NC));
                2: a = A_CNT + 12'($urandom_range(0, NC));
                3: a = A_CNTH + 12'($urandom_range(0, NC));
                4: a = A_OVF;
                default: a = 12'($urandom);
            endcase
            w = ($urandom_range(0, 2) == 0);
            cyc(w, a, $urandom, 8'($urandom & $urandom), rand_cval());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_hpm_ctrl.md
IBEX_HPM_CTRL -- requirements
Module: ibex_hpm_ctrl

Interface
REQ-001 SHALL have parameter NumCounters, default 4, meaning the number of HPM counters driven (mhpmcounter3..3+NumCounters-1); legal range 1..29.
REQ-002 SHALL have parameter NumEvents, default 8, meaning the width of the event bus and of each event-select register.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port csr_we_i, input, 1, CSR write strobe, valid for one cycle.
REQ-006 SHALL have port csr_addr_i, input, 12, CSR address for read and write.
REQ-007 SHALL have port csr_wdata_i, input, 32, CSR write data.
REQ-008 SHALL have port csr_rdata_o, output, 32, combinational read data for the control CSRs owned by this block.
REQ-009 SHALL have port events_i, input, NumEvents, single-cycle event pulses from the core.
REQ-010 SHALL have port counter_val_i, input, NumCounters*64, packed current counter values; counter i occupies bits [64i+63:64i].
REQ-011 SHALL have port counter_inc_o, input-to-counter, NumCounters, per-counter increment enable.
REQ-012 SHALL have ports counter_we_o and counterh_we_o, output, NumCounters each, per-counter low-word and high-word load strobes.
REQ-013 SHALL have port counter_wdata_o, output, 32, load data shared by all counters (equal to csr_wdata_i).
REQ-014 SHALL have port ovf_irq_o, output, 1, level overflow interrupt.

Function
REQ-015 SHALL hold mcountinhibit_q (address 0x320); bit 3+i inhibits counter i; all other bits read 0 and are not stored.
REQ-016 SHALL hold mhpmevent_q[i] (address 0x323+i), NumEvents bits; wdata bits above NumEvents-1 are dropped and read back as 0.
REQ-017 SHALL register events_i into events_q with exactly one cycle of latency.
REQ-018 SHALL drive counter_inc_o[i] = |(events_q & mhpmevent_q[i]) & ~mcountinhibit_q[3+i] & ~(counter_we_o[i] | counterh_we_o[i]).
REQ-019 SHALL assert counter_we_o[i] combinationally when csr_we_i is high and csr_addr_i==0xB03+i, and counterh_we_o[i] when the address is 0xB83+i.
REQ-020 SHALL make writes to mcountinhibit and mhpmevent take effect from the next cycle; an event in events_q in the write cycle uses the old settings.
REQ-021 SHALL, when a write to a counter half coincides with a qualifying event, suppress that increment: the written value wins and the event is lost.
REQ-022 SHALL return 0 on csr_rdata_o for unowned addresses and for counter addresses (counter reads are served elsewhere).
REQ-023 SHALL ignore writes to counter or event indices at or above NumCounters.

Reset
REQ-024 SHALL, on rst_ni low, asynchronously clear mcountinhibit_q, all mhpmevent_q, events_q and all overflow flags; all outputs SHALL then be 0.
REQ-025 SHALL drop any in-flight registered event on reset mid-operation; the first increment is possible two cycles after reset release.

Configuration
REQ-026 SHALL, with IBEX_HPM_OVF_IRQ_EN defined, set sticky flag ovf_q[i] the cycle after counter_inc_o[i] is high while counter i equals 64'hFFFF_FFFF_FFFF_FFFF; ovf_irq_o SHALL equal |ovf_q.
REQ-027 SHALL, with the macro defined, expose ovf_q at CSR 0x7C0, bit i; writing 1 clears the bit; a same-cycle set wins over clear.
REQ-028 SHALL, without IBEX_HPM_OVF_IRQ_EN, instantiate no overflow state, tie ovf_irq_o to 0 and read 0x7C0 as 0.

Structure
REQ-029 SHALL place CSR address constants (0x320, 0x323, 0xB03, 0xB83, 0x7C0) in the shared ibex_pkg.
REQ-030 SHALL use one sub-module, ibex_hpm_event_sel, per counter: event mask, inhibit and write-suppression logic producing counter_inc_o[i].

Verification
REQ-031 SHALL cover: mhpmevent3=0x01, events_i[0] pulse at cycle t -> counter_inc_o[0]=1 at cycle t+1 only.
REQ-032 SHALL cover: mcountinhibit=0x8, events_i[0] pulsing -> counter_inc_o[0] stays 0; clear inhibit -> increments resume the cycle after.
REQ-033 SHALL cover: write 0x1234 to 0xB03 in the same cycle as a qualifying event_q -> counter_we_o[0]=1, counter_inc_o[0]=0, counter_wdata_o=0x1234.
REQ-034 SHALL cover: macro defined, counter 0 at all-ones and an increment -> ovf_irq_o=1 the next cycle; write 0x1 to 0x7C0 -> ovf_irq_o=0.
REQ-035 SHALL cover: write 0xFFFF_FFFF to 0x323 with NumEvents=8 -> reads back 0x0000_00FF; reset asserted mid-stream -> all outputs 0 immediately.
